// File: rtl/pc_sequencer.sv
// Fetch-address generator: sequential, stall, PC-relative branch, branch-with-link
// and return predicted through a circular return-address stack.
module pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    IMM_WIDTH    = 24,
    parameter int                    RAS_DEPTH    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                           clk,
    input  logic                           Reset,
    input  logic                           stall,
    input  logic                           branch,
    input  logic                           link,
    input  logic                           ret,
    input  logic [IMM_WIDTH-1:0]           branchImmediate,
    output logic [ADDR_WIDTH-1:0]          pc,
    output logic [ADDR_WIDTH-1:0]          pc_plus4,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      top;
    logic [ADDR_WIDTH-1:0] imm_ext;
    logic [ADDR_WIDTH-1:0] target;
    logic                  do_pop;
    logic                  do_push;

    assign pc_plus4 = pc + ADDR_WIDTH'(4);
    assign imm_ext  = {{(ADDR_WIDTH-IMM_WIDTH){branchImmediate[IMM_WIDTH-1]}}, branchImmediate};
    assign target   = pc_plus4 + (imm_ext << 2);

    assign do_pop  = !stall && ret && (ras_count != '0);
    assign do_push = !stall && !ret && branch && link;

    // Stack contents need no reset; only the pointer and count define validity.
    always_ff @(posedge clk) begin
        if (!Reset && do_push) begin
            ras_mem[top + PTR_W'(1)] <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pc            <= RESET_VECTOR;
            top           <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            if (!stall) begin
                if (ret) begin
                    if (do_pop) begin
                        pc        <= ras_mem[top];
                        top       <= top - PTR_W'(1);
                        ras_count <= ras_count - CNT_W'(1);
                    end else begin
                        pc            <= pc_plus4;
                        ras_underflow <= 1'b1;
                    end
                end else if (branch) begin
                    pc <= target;
                    if (link) begin
                        top <= top + PTR_W'(1);
                        // A full stack wraps onto the oldest entry instead of growing.
                        if (ras_count == CNT_W'(RAS_DEPTH)) begin
                            ras_overflow <= 1'b1;
                        end else begin
                            ras_count <= ras_count + CNT_W'(1);
                        end
                    end
                end else begin
                    pc <= pc_plus4;
                end
            end
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised fetch-address generator for the single-cycle ARM datapath; it supersedes the fixed-width PC register. It produces the instruction-fetch address each cycle and supports stall, signed PC-relative branch, branch-with-link and return. Returns are predicted through an internal return-address stack (RAS), so `ret` needs no register-file read. It sits between the control unit and the instruction memory address port.

## Interface
- `ADDR_WIDTH`, 32: width of the PC and of every stored return address.
- `IMM_WIDTH`, 24: width of the signed word-offset branch immediate.
- `RAS_DEPTH`, 4: return-stack entries; must be ≥2 and a power of two.
- `RESET_VECTOR`, 0: PC value loaded by reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the PC and stack this cycle.
- `branch`  in  1  take a PC-relative branch.
- `link`  in  1  qualifies `branch`: push the return address.
- `ret`  in  1  return to the address on top of the RAS.
- `branchImmediate`  in  IMM_WIDTH  signed word offset.
- `pc`  out  ADDR_WIDTH  current fetch address (registered).
- `pc_plus4`  out  ADDR_WIDTH  `pc + 4`, combinational.
- `ras_count`  out  clog2(RAS_DEPTH)+1  valid RAS entries (registered).
- `ras_overflow`  out  1  one-cycle pulse: a push dropped the oldest entry.
- `ras_underflow`  out  1  one-cycle pulse: `ret` found the RAS empty.

## Operation
- **Reset** (sampled at an edge):
  - `pc`=RESET_VECTOR, `ras_count`=0, both pulses 0.
  - RAS entry contents are don't-care.
  - Reset wins over all other inputs.
- **Priority** below reset: `stall` > `ret` > `branch` > sequential.
- **stall**:
  - `pc` and the RAS are unchanged.
  - `branch`, `link` and `ret` are ignored.
  - Pulses are 0 the following cycle.
- **Sequential**: next `pc` = `pc + 4`.
- **Branch target** = `pc + 4 + (sign_extend(branchImmediate) << 2)`.
  - Sign-extend to ADDR_WIDTH before the shift.
  - All sums wrap modulo 2^ADDR_WIDTH; there is no overflow detection.
- **branch with link**:
  - Push `pc + 4`, then jump to the branch target.
  - `link` without `branch` is ignored.
- **ret with RAS non-empty**:
  - Next `pc` = top entry; the entry is popped and `ras_count` decrements.
- **ret with RAS empty**:
  - Next `pc` = `pc + 4`; `ras_count` stays 0.
  - `ras_underflow` pulses.
- **ret and branch in the same cycle**:
  - `ret` wins; `branch` and `link` are ignored, so no push happens.
- **Push when full** (`ras_count`=RAS_DEPTH):
  - The RAS is circular: the oldest entry is overwritten by the new one.
  - `ras_count` stays at RAS_DEPTH; `ras_overflow` pulses.
- **RAS structure**: a circular buffer with a top pointer modulo RAS_DEPTH.
  - Push: write at top+1, then advance top.
  - Pop: read at top, then retreat top.
- **Alignment**: `pc[1:0]` is always 0 when the immediate is in range; the block does not check alignment.

## Timing
- Every control input is sampled at rising edge N; the resulting `pc` is visible after edge N.
  - One-cycle latency, no bubbles.
- `pc_plus4` follows `pc` combinationally in the same cycle.
- `ras_count` updates at the same edge as `pc`.
- `ras_overflow` and `ras_underflow` are registered.
  - High for exactly the one cycle after the causing edge; 0 otherwise.
- A `ret` immediately after a branch-with-link returns to the address pushed at the previous edge.
  - No forwarding hazard: the RAS write is visible to the next cycle's read.
- Reset asserted mid-sequence: the PC returns to RESET_VECTOR and the RAS empties at that edge.
  - Pending pulses clear.

## Test plan
All scenarios use ADDR_WIDTH=32, IMM_WIDTH=24, RAS_DEPTH=4, RESET_VECTOR=0.
- **Reset and sequential**: Reset 1 cycle, then 5 idle cycles -> `pc` = 0, 4, 8, 12, 16, 20; `ras_count`=0; pulses never set.
- **Stall**: at `pc`=0x10, stall for 3 cycles with `branch`=1 and `ret`=1 also held -> `pc` holds 0x10 for all 3 cycles; `ras_count` unchanged; then `pc`=0x14.
- **Branch wrap and sign**: the bench makes one edge of each case, starting from the `pc` given for it.
  - At `pc`=0x20, imm=0xFFFFFD (−3) -> next `pc`=0x18.
  - At `pc`=0, imm=0x800000 -> next `pc`=0xFE000004.
  - At `pc`=0xFFFFFFFC, sequential -> next `pc`=0.
- **Call/return**: at `pc`=0x100, branch+link with imm=0x40 -> `pc`=0x204, `ras_count`=1; 2 idle cycles; then `ret` -> `pc`=0x104, `ras_count`=0.
- **Overflow then underflow**:
  - 5 branch+link pushes, with push addresses A1..A5 -> `ras_overflow` pulses once after the 5th push; `ras_count`=4.
  - 4 rets -> `pc` takes A5, A4, A3, A2 in turn.
  - A 5th ret -> `pc + 4`, and `ras_underflow` pulses.
- **Priority and reset mid-operation**:
  - `ret`+`branch`+`link` together with `ras_count`=2 -> pop taken, `ras_count`=1, no push.
  - Reset asserted with `ras_count`=3 and `ret` high -> `pc`=0, `ras_count`=0.
